// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI round-robin bus arbiter.
package pci_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_GNT, S_BUSY, S_TURN} arb_state_e;

  // PCI request/grant lines are active-low.
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  function automatic int own_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmr_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin pick: first active request after i_rr_ptr, wrapping at NUM_DEV.
module pci_rr_pick
  import pci_arb_pkg::*;
#(
  parameter  int NUM_DEV = 5,
  localparam int OWN_W   = own_w(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] i_req,
  input  logic [OWN_W-1:0]   i_rr_ptr,
  output logic [OWN_W-1:0]   o_winner,
  output logic               o_any_req
);

  // Scan from farthest to nearest so the closest request after the pointer lands last.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    for (int k = NUM_DEV; k >= 1; k--) begin
      int idx;
      idx = (int'(i_rr_ptr) + k) % NUM_DEV;
      if (i_req[idx]) begin
        o_winner  = OWN_W'(idx);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: round-robin grants, one-cycle turnaround, unused-grant timeout.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int NUM_DEV     = 5,
  parameter  int GNT_TIMEOUT = 16,
  parameter  int PARK_DEV    = 0,
  localparam int OWN_W       = own_w(NUM_DEV),
  localparam int TMR_W       = tmr_w(GNT_TIMEOUT)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_DEV-1:0] i_req_n,
  input  logic               i_frame_n,
  input  logic               i_irdy_n,
  output logic [NUM_DEV-1:0] o_gnt_n,
  output logic [OWN_W-1:0]   o_owner,
  output logic               o_owner_vld,
  output logic               o_timeout_pulse
);

  if (NUM_DEV < 2 || NUM_DEV > 8) begin : g_bad_ndev
    $error("NUM_DEV must be 2..8");
  end
  if (GNT_TIMEOUT < 2) begin : g_bad_tmo
    $error("GNT_TIMEOUT must be >= 2");
  end
  if (PARK_DEV < 0 || PARK_DEV >= NUM_DEV) begin : g_bad_park
    $error("PARK_DEV out of range");
  end

  arb_state_e         r_state, w_state;
  logic [NUM_DEV-1:0] r_gnt_n, w_gnt_n;
  logic [OWN_W-1:0]   r_owner, w_owner;
  logic [OWN_W-1:0]   r_rr_ptr, w_rr_ptr;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic               r_owner_vld, w_owner_vld;
  logic               r_timeout, w_timeout;

  logic [NUM_DEV-1:0] w_req;
  logic [OWN_W-1:0]   w_winner;
  logic               w_any_req, w_bus_idle, w_own_req, w_other_req;

  function automatic logic [NUM_DEV-1:0] gnt_vec(input logic [OWN_W-1:0] idx);
    gnt_vec      = {NUM_DEV{DEASSERTED}};
    gnt_vec[idx] = ASSERTED;
  endfunction

  assign w_req       = ~i_req_n;
  assign w_bus_idle  = i_frame_n & i_irdy_n;
  assign w_own_req   = w_req[r_owner];
  assign w_other_req = |(w_req & gnt_vec(r_owner));

  pci_rr_pick #(.NUM_DEV(NUM_DEV)) u_pick (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

`ifdef PCI_ARB_PARK_EN
  logic [OWN_W-1:0] r_park, w_park;
  logic             w_parked;
  assign w_parked = (r_state == S_IDLE) && r_owner_vld;
`endif

  always_comb begin
    w_state     = r_state;
    w_gnt_n     = r_gnt_n;
    w_owner     = r_owner;
    w_owner_vld = r_owner_vld;
    w_rr_ptr    = r_rr_ptr;
    w_timer     = r_timer;
    w_timeout   = 1'b0;
`ifdef PCI_ARB_PARK_EN
    w_park      = r_park;
`endif
    case (r_state)
      S_IDLE: begin
        w_gnt_n     = '1;
        w_owner_vld = 1'b0;
`ifdef PCI_ARB_PARK_EN
        if (w_parked && !i_frame_n) begin
          // Parked master starts a transaction without ever requesting.
          w_state     = S_BUSY;
          w_gnt_n     = r_gnt_n;
          w_owner_vld = 1'b1;
          w_rr_ptr    = r_owner;
          w_park      = r_owner;
        end else if (w_parked && w_other_req) begin
          w_state = S_TURN;
        end else if (w_parked && w_own_req) begin
          w_state     = S_GNT;
          w_gnt_n     = r_gnt_n;
          w_owner_vld = 1'b1;
          w_timer     = '0;
        end else if (w_any_req && w_bus_idle) begin
          w_state     = S_GNT;
          w_gnt_n     = gnt_vec(w_winner);
          w_owner     = w_winner;
          w_owner_vld = 1'b1;
          w_timer     = '0;
        end else if (w_bus_idle) begin
          w_gnt_n     = gnt_vec(r_park);
          w_owner     = r_park;
          w_owner_vld = 1'b1;
        end
`else
        if (w_any_req && w_bus_idle) begin
          w_state     = S_GNT;
          w_gnt_n     = gnt_vec(w_winner);
          w_owner     = w_winner;
          w_owner_vld = 1'b1;
          w_timer     = '0;
        end
`endif
      end
      S_GNT: begin
        if (!i_frame_n) begin
          // A starting transaction beats a timeout expiring on the same edge.
          w_state  = S_BUSY;
          w_rr_ptr = r_owner;
`ifdef PCI_ARB_PARK_EN
          w_park   = r_owner;
`endif
        end else if (!w_own_req) begin
          w_state     = S_TURN;
          w_gnt_n     = '1;
          w_owner_vld = 1'b0;
        end else if (r_timer == TMR_W'(GNT_TIMEOUT - 1)) begin
          w_state     = S_TURN;
          w_gnt_n     = '1;
          w_owner_vld = 1'b0;
          w_timeout   = 1'b1;
          w_rr_ptr    = r_owner;
        end else if (r_timer != '1) begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_BUSY: begin
        if (w_bus_idle) begin
          w_state     = S_TURN;
          w_gnt_n     = '1;
          w_owner_vld = 1'b0;
        end else if (!w_own_req || w_other_req) begin
          // Release is sticky: owner finishes its current transaction only.
          w_gnt_n = '1;
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_gnt_n     = '1;
        w_owner_vld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt_n     <= '1;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_timeout   <= 1'b0;
      r_rr_ptr    <= OWN_W'(NUM_DEV - 1);
      r_timer     <= '0;
`ifdef PCI_ARB_PARK_EN
      r_park      <= OWN_W'(PARK_DEV);
`endif
    end else begin
      r_state     <= w_state;
      r_gnt_n     <= w_gnt_n;
      r_owner     <= w_owner;
      r_owner_vld <= w_owner_vld;
      r_timeout   <= w_timeout;
      r_rr_ptr    <= w_rr_ptr;
      r_timer     <= w_timer;
`ifdef PCI_ARB_PARK_EN
      r_park      <= w_park;
`endif
    end
  end

  assign o_gnt_n         = r_gnt_n;
  assign o_owner         = r_owner;
  assign o_owner_vld     = r_owner_vld;
  assign o_timeout_pulse = r_timeout;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed scoreboard bench for pci_rr_arbiter (NUM_DEV=5, GNT_TIMEOUT=16).
module tb_pci_rr_arbiter;

  typedef struct packed {
    logic [4:0] gnt;
    logic       vld;
    logic       to;
    logic       ochk;
    logic [2:0] own;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req_n = 5'b11111;
  logic       frame_n = 1'b1;
  logic       irdy_n = 1'b1;
  logic [4:0] gnt_n;
  logic [2:0] owner;
  logic       owner_vld;
  logic       timeout_pulse;

  exp_t  sb[$];
  string tq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pci_rr_arbiter dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_n         (req_n),
    .i_frame_n       (frame_n),
    .i_irdy_n        (irdy_n),
    .o_gnt_n         (gnt_n),
    .o_owner         (owner),
    .o_owner_vld     (owner_vld),
    .o_timeout_pulse (timeout_pulse)
  );

  function automatic logic [4:0] gv(input logic [2:0] d);
    logic [4:0] v;
    v    = 5'b11111;
    v[d] = 1'b0;
    return v;
  endfunction

  task automatic check_out();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tq.pop_front();
    checks++;
    assert (gnt_n === e.gnt) else begin
      errors++; $error("FAIL %s gnt_n observed %b expected %b", t, gnt_n, e.gnt);
    end
    checks++;
    assert (owner_vld === e.vld) else begin
      errors++; $error("FAIL %s owner_vld observed %b expected %b", t, owner_vld, e.vld);
    end
    checks++;
    assert (timeout_pulse === e.to) else begin
      errors++; $error("FAIL %s timeout_pulse observed %b expected %b", t, timeout_pulse, e.to);
    end
    if (e.ochk) begin
      checks++;
      assert (owner === e.own) else begin
        errors++; $error("FAIL %s owner observed %0d expected %0d", t, owner, e.own);
      end
    end
  endtask

  // Drive one cycle of inputs, queue what the edge must produce, then compare.
  task automatic step(input logic r, input logic [4:0] rq, input logic fr, input logic ir,
                      input logic [4:0] eg, input logic ev, input logic et,
                      input logic oc, input logic [2:0] eo, input string tag);
    exp_t e;
    rst = r; req_n = rq; frame_n = fr; irdy_n = ir;
    e.gnt = eg; e.vld = ev; e.to = et; e.ochk = oc; e.own = eo;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk); #1;
    check_out();
  endtask

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 4, 0};

    // Reset with every device requesting
    step(1, 5'b00000, 1, 1, 5'b11111, 0, 0, 1, 0, "reset0");
    step(1, 5'b00000, 1, 1, 5'b11111, 0, 0, 1, 0, "reset1");

`ifdef PCI_ARB_PARK_EN
    step(0, 5'b11111, 1, 1, 5'b11110, 1, 0, 1, 0, "park_dev0");
    step(0, 5'b11111, 0, 0, 5'b11110, 1, 0, 1, 0, "park_frame");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "park_turn");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "park_idle");
    step(0, 5'b11111, 1, 1, 5'b11110, 1, 0, 1, 0, "park_again");
    step(0, 5'b10111, 1, 1, 5'b11111, 0, 0, 0, 0, "park_release");
    step(0, 5'b10111, 1, 1, 5'b11111, 0, 0, 0, 0, "park_gap");
    step(0, 5'b10111, 1, 1, 5'b10111, 1, 0, 1, 3, "park_grant3");
`else
    // Round robin with all requesting, one data phase each
    for (int k = 0; k < 6; k++) begin
      logic [2:0] d;
      d = 3'(order[k]);
      step(0, 5'b00000, 1, 1, gv(d),    1, 0, 1, d, "rr_grant");
      step(0, 5'b00000, 0, 0, gv(d),    1, 0, 1, d, "rr_frame");
      step(0, 5'b00000, 1, 0, 5'b11111, 1, 0, 1, d, "rr_release");
      step(0, 5'b00000, 1, 1, 5'b11111, 0, 0, 0, 0, "rr_turn");
      step(0, 5'b00000, 1, 1, 5'b11111, 0, 0, 0, 0, "rr_idle");
    end

    // Single requester, three busy cycles
    step(1, 5'b11111, 1, 1, 5'b11111, 0, 0, 1, 0, "reset2");
    step(0, 5'b11011, 1, 1, 5'b11011, 1, 0, 1, 2, "one_grant");
    step(0, 5'b11011, 0, 0, 5'b11011, 1, 0, 1, 2, "one_busy0");
    step(0, 5'b11011, 0, 0, 5'b11011, 1, 0, 1, 2, "one_busy1");
    step(0, 5'b11011, 0, 0, 5'b11011, 1, 0, 1, 2, "one_busy2");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "one_turn");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "one_idle");

    // Unused grant revoked after GNT_TIMEOUT cycles
    step(1, 5'b11111, 1, 1, 5'b11111, 0, 0, 1, 0, "reset3");
    step(0, 5'b11101, 1, 1, 5'b11101, 1, 0, 1, 1, "to_grant");
    for (int k = 0; k < 15; k++)
      step(0, 5'b11101, 1, 1, 5'b11101, 1, 0, 1, 1, "to_wait");
    step(0, 5'b11101, 1, 1, 5'b11111, 0, 1, 0, 0, "to_revoke");
    step(0, 5'b11100, 1, 1, 5'b11111, 0, 0, 0, 0, "to_turn");
    step(0, 5'b11100, 1, 1, 5'b11110, 1, 0, 1, 0, "to_next_dev0");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "wd0_turn");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "wd0_idle");

    // Request withdrawn before frame, then reset during a transaction
    step(0, 5'b11011, 1, 1, 5'b11011, 1, 0, 1, 2, "wd_grant");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "wd_release");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "wd_idle");
    step(0, 5'b11011, 1, 1, 5'b11011, 1, 0, 1, 2, "rb_grant");
    step(0, 5'b11011, 0, 0, 5'b11011, 1, 0, 1, 2, "rb_busy0");
    step(0, 5'b11011, 0, 0, 5'b11011, 1, 0, 1, 2, "rb_busy1");
    step(1, 5'b11011, 0, 0, 5'b11111, 0, 0, 1, 0, "rb_reset");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "rb_idle");

    // Foreign master on the bus, then frame on the timeout edge
    step(0, 5'b10111, 0, 0, 5'b11111, 0, 0, 0, 0, "foreign_frame");
    step(0, 5'b10111, 1, 0, 5'b11111, 0, 0, 0, 0, "foreign_irdy");
    step(0, 5'b10111, 1, 1, 5'b10111, 1, 0, 1, 3, "foreign_grant");
    for (int k = 0; k < 15; k++)
      step(0, 5'b10111, 1, 1, 5'b10111, 1, 0, 1, 3, "race_wait");
    step(0, 5'b10111, 0, 0, 5'b10111, 1, 0, 1, 3, "race_frame");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "race_turn");
    step(0, 5'b11111, 1, 1, 5'b11111, 0, 0, 0, 0, "race_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
